// File: rtl/jt9346_host.sv
// Serial master for 93C46-style EEPROMs: turns one parallel command into a
// start+op+addr(+data) frame on scs/sclk/sdi, captures READ data and polls ready/busy.
module jt9346_host #(
    parameter int AW   = 6,
    parameter int CW   = AW,
    parameter int DW   = 16,
    parameter int HDIV = 4,
    parameter int TMO  = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [CW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_din,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          timeout,
    output logic          scs,
    output logic          sclk,
    output logic          sdi,
    input  logic          sdo
);
    localparam int FW = 3 + CW;
    localparam int SW = (FW > DW) ? FW : DW;
    localparam int BW = $clog2(SW);
    localparam int PW = $clog2(TMO) + 1;
    localparam logic [7:0]    DIV_LAST   = 8'(HDIV - 1);
    localparam logic [BW-1:0] FRAME_LAST = BW'(FW - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DW - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(TMO - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_CMD, S_RDATA, S_WDATA, S_GAP, S_POLL, S_END, S_NOP
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    div_reg;
    logic          hi_reg;
    logic [BW-1:0] bit_reg;
    logic [PW-1:0] poll_reg;
    logic [SW-1:0] tx_reg;
    logic [DW-2:0] rx_reg;
    logic [2:0]    op_reg;
    logic [DW-1:0] din_reg;
    logic [DW-1:0] rd_data_reg;
    logic          scs_reg, sclk_reg, sdi_reg, rd_valid_reg, timeout_reg;

    logic          tick, rise, fall, accept, is_bit_state, shift_bit;
    logic [1:0]    op_bits;
    logic [CW-1:0] addr_bits;
    logic [SW-1:0] frame_al, din_al;

    // Each bit (and each GAP/END half) is two HDIV-long phases tracked by hi_reg.
    assign tick   = (div_reg == DIV_LAST);
    assign rise   = tick && !hi_reg;
    assign fall   = tick && hi_reg;
    assign accept = cmd_valid && (state_reg == S_IDLE);
    assign is_bit_state = (state_reg == S_CMD) || (state_reg == S_RDATA) ||
                          (state_reg == S_WDATA) || (state_reg == S_POLL);

    // Short commands (EWEN/EWDS/ERAL/WRAL) carry their sub-opcode in the top address bits.
    always_comb begin
        op_bits   = 2'b00;
        addr_bits = cmd_addr;
        case (cmd_op)
            3'd0: op_bits = 2'b10;
            3'd1: op_bits = 2'b01;
            3'd2: op_bits = 2'b11;
            3'd3: begin addr_bits = '0; addr_bits[CW-1 -: 2] = 2'b11; end
            3'd4: begin addr_bits = '0; addr_bits[CW-1 -: 2] = 2'b00; end
            3'd5: begin addr_bits = '0; addr_bits[CW-1 -: 2] = 2'b10; end
            3'd6: begin addr_bits = '0; addr_bits[CW-1 -: 2] = 2'b01; end
            default: addr_bits = '0;
        endcase
        frame_al = '0;
        frame_al[SW-1 -: FW] = {1'b1, op_bits, addr_bits};
        din_al = '0;
        din_al[SW-1 -: DW] = din_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (cmd_valid) state_next = (cmd_op == 3'd7) ? S_NOP : S_SETUP;
            S_SETUP: if (tick) state_next = S_CMD;
            S_CMD: begin
                if (fall && bit_reg == FRAME_LAST) begin
                    case (op_reg)
                        3'd0:       state_next = S_RDATA;
                        3'd1, 3'd6: state_next = S_WDATA;
                        3'd2, 3'd5: state_next = S_GAP;
                        default:    state_next = S_END;
                    endcase
                end
            end
            S_RDATA: if (fall && bit_reg == DATA_LAST) state_next = S_END;
            S_WDATA: if (fall && bit_reg == DATA_LAST) state_next = S_GAP;
            S_GAP:   if (fall) state_next = S_POLL;
            S_POLL:  if (fall && (sdo || poll_reg == POLL_LAST)) state_next = S_END;
            S_END:   if (fall) state_next = S_IDLE;
            S_NOP:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign shift_bit = (state_reg == S_SETUP && tick) ||
                       ((state_reg == S_CMD || state_reg == S_WDATA) && fall && state_next == state_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            div_reg      <= '0;
            hi_reg       <= 1'b0;
            bit_reg      <= '0;
            poll_reg     <= '0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            op_reg       <= '0;
            din_reg      <= '0;
            rd_data_reg  <= '0;
            scs_reg      <= 1'b0;
            sclk_reg     <= 1'b0;
            sdi_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_valid_reg <= 1'b0;
            scs_reg      <= (state_next == S_SETUP) || (state_next == S_CMD) || (state_next == S_RDATA) ||
                            (state_next == S_WDATA) || (state_next == S_POLL);
            sclk_reg     <= is_bit_state && (rise || (hi_reg && !tick));

            if (state_reg == S_IDLE || state_next != state_reg) begin
                div_reg <= '0;
                hi_reg  <= 1'b0;
            end else if (tick) begin
                div_reg <= '0;
                hi_reg  <= ~hi_reg;
            end else begin
                div_reg <= div_reg + 8'd1;
            end

            if (state_next != state_reg) bit_reg <= '0;
            else if (fall) bit_reg <= bit_reg + 1'b1;

            if (accept) begin
                op_reg      <= cmd_op;
                din_reg     <= cmd_din;
                tx_reg      <= frame_al;
                timeout_reg <= 1'b0;
            end

            // sdi only moves at the start of a low phase.
            if (shift_bit) begin
                sdi_reg <= tx_reg[SW-1];
                tx_reg  <= tx_reg << 1;
            end else if (state_reg == S_CMD && state_next == S_WDATA) begin
                sdi_reg <= din_reg[DW-1];
                tx_reg  <= din_al << 1;
            end else if (state_next != state_reg) begin
                sdi_reg <= 1'b0;
            end

            if (state_reg == S_RDATA && fall) begin
                rx_reg <= {rx_reg[DW-3:0], sdo};
                if (state_next == S_END) begin
                    rd_data_reg  <= {rx_reg, sdo};
                    rd_valid_reg <= 1'b1;
                end
            end

            if (state_next != state_reg) poll_reg <= '0;
            else if (state_reg == S_POLL && fall) poll_reg <= poll_reg + 1'b1;
            if (state_reg == S_POLL && fall && !sdo && poll_reg == POLL_LAST) timeout_reg <= 1'b1;
        end
    end

    assign cmd_ready = (state_reg == S_IDLE);
    assign done      = (state_reg == S_NOP) || (state_reg == S_END && fall);
    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rd_data_reg;
    assign timeout   = timeout_reg;
    assign scs       = scs_reg;
    assign sclk      = sclk_reg;
    assign sdi       = sdi_reg;
endmodule

// File: tb/tb_jt9346_host.sv
// Directed bench for jt9346_host against a small behavioural 93C46 (64x16) model.
module tb_jt9346_host;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd7;
    logic [5:0]  cmd_addr = '0;
    logic [15:0] cmd_din = '0;
    logic        rd_valid, done, timeout, scs, sclk, sdi, sdo;
    logic [15:0] rd_data;

    jt9346_host #(.AW(6), .CW(6), .DW(16), .HDIV(4), .TMO(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_din(cmd_din),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .timeout(timeout),
        .scs(scs), .sclk(sclk), .sdi(sdi), .sdo(sdo)
    );

    always #5 clk = ~clk;

    // EEPROM model, evaluated on the falling clk edge so pins are stable.
    logic [15:0] mem [64];
    logic [7:0]  hdr = '0;
    logic [15:0] wsh = '0, rd_word = '0;
    logic        sdo_m = 1'b0, ewen = 1'b0, stuck = 1'b0, sclk_q = 1'b0, scs_q = 1'b0;
    int          cnt = 0, rises = 0, busy = 0;

    assign sdo = stuck ? 1'b0 : ((cnt == 0) ? (busy == 0) : sdo_m);

    always @(negedge clk) begin
        if (scs && !scs_q) rises = 0;
        if (scs && sclk && !sclk_q) begin
            rises++;
            if (cnt == 0) begin
                if (sdi) cnt = 1;
            end else begin
                if (cnt >= 9 && hdr[7:6] == 2'b10 && cnt <= 24) sdo_m = rd_word[24 - cnt];
                if (cnt <= 8) hdr = {hdr[6:0], sdi};
                else wsh = {wsh[14:0], sdi};
                cnt++;
                if (cnt == 9 && hdr[7:6] == 2'b10) begin
                    rd_word = mem[hdr[5:0]];
                    sdo_m = 1'b0;
                end
            end
        end
        if (!scs && scs_q) begin
            if (cnt == 9) begin
                if (hdr[7:4] == 4'b0011) ewen = 1'b1;
                else if (hdr[7:4] == 4'b0000) ewen = 1'b0;
                else if (hdr[7:4] == 4'b0010 && ewen) begin
                    for (int i = 0; i < 64; i++) mem[i] = 16'hFFFF;
                    busy = 40;
                end else if (hdr[7:6] == 2'b11 && ewen) begin
                    mem[hdr[5:0]] = 16'hFFFF;
                    busy = 40;
                end
            end else if (cnt == 25 && ewen) begin
                if (hdr[7:6] == 2'b01) begin
                    mem[hdr[5:0]] = wsh;
                    busy = 40;
                end else if (hdr[7:4] == 4'b0001) begin
                    for (int i = 0; i < 64; i++) mem[i] = wsh;
                    busy = 40;
                end
            end
            cnt = 0;
        end
        if (busy > 0) busy--;
        sclk_q = sclk;
        scs_q  = scs;
    end

    int          total = 0, bad = 0;
    logic        ok, got, to, scs_seen, upd;
    int          rdv, cyc, n, acc, nrd, lowcnt, minlow, seen, errs;
    logic [15:0] rdw [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a falling edge; inputs are scrambled after accept to prove they were latched.
    task automatic issue(input logic [2:0] op, input logic [5:0] a, input logic [15:0] d, output logic acc_ok);
        int k = 0;
        cmd_op = op; cmd_addr = a; cmd_din = d; cmd_valid = 1'b1;
        while (!cmd_ready && k < 2000) begin @(negedge clk); k++; end
        acc_ok = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd2; cmd_addr = 6'h3F; cmd_din = 16'hDEAD;
    endtask

    task automatic wait_done(input int limit, output logic g, output logic t, output int rv,
                             output int cy, output logic ss);
        g = 1'b0; t = 1'b0; rv = 0; ss = 1'b0;
        for (cy = 0; cy < limit; cy++) begin
            if (scs) ss = 1'b1;
            if (rd_valid) rv++;
            if (done) begin g = 1'b1; t = timeout; break; end
            @(negedge clk);
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [5:0] a, input logic [15:0] d);
        issue(op, a, d, ok);
        wait_done(3000, got, to, rdv, cyc, scs_seen);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_scs", scs, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_sdi", sdi, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rdvalid", rd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_rddata", rd_data, 0);
        rst = 1'b0;
        @(negedge clk);

        run(3'd3, 6'h00, 16'h0000);
        chk("ewen_done", got, 1);
        chk("ewen_to", to, 0);
        run(3'd1, 6'h05, 16'hA55A);
        chk("wr5_done", got, 1);
        chk("wr5_to", to, 0);
        chk("wr5_mem", mem[5], 16'hA55A);

        run(3'd0, 6'h05, 16'h0000);
        chk("rd5_done", got, 1);
        chk("rd5_valid_cnt", rdv, 1);
        chk("rd5_data", rd_data, 16'hA55A);
        chk("rd5_rises", rises, 25);

        run(3'd1, 6'h00, 16'h1111);
        chk("wr0_mem", mem[0], 16'h1111);
        run(3'd1, 6'h01, 16'h2222);
        chk("wr1_mem", mem[1], 16'h2222);
        run(3'd1, 6'h02, 16'h3333);
        chk("wr2_mem", mem[2], 16'h3333);

        // Back-to-back READs with cmd_valid held high.
        cmd_op = 3'd0; cmd_addr = 6'd0; cmd_valid = 1'b1;
        acc = 0; nrd = 0; lowcnt = 0; minlow = 1000; seen = 0; upd = 1'b0;
        for (int c = 0; c < 3000 && nrd < 3; c++) begin
            if (rd_valid) begin rdw[nrd] = rd_data; nrd++; end
            if (scs) begin
                if (seen != 0 && lowcnt > 0 && lowcnt < minlow) minlow = lowcnt;
                seen = 1; lowcnt = 0;
            end else lowcnt++;
            if (cmd_ready && cmd_valid) begin acc++; upd = 1'b1; end
            @(negedge clk);
            if (upd) begin
                upd = 1'b0;
                cmd_addr = 6'(acc);
                if (acc == 3) cmd_valid = 1'b0;
            end
        end
        wait_done(200, got, to, rdv, cyc, scs_seen);
        chk("b2b_accepts", acc, 3);
        chk("b2b_reads", nrd, 3);
        chk("b2b_rd0", rdw[0], 16'h1111);
        chk("b2b_rd1", rdw[1], 16'h2222);
        chk("b2b_rd2", rdw[2], 16'h3333);
        chk("b2b_cs_gap_ge8", minlow >= 8, 1);

        run(3'd2, 6'h05, 16'h0000);
        chk("erase_done", got, 1);
        chk("erase_mem", mem[5], 16'hFFFF);
        chk("erase_keeps_rddata", rd_data, 16'h3333);
        run(3'd0, 6'h05, 16'h0000);
        chk("rd_erased", rd_data, 16'hFFFF);

        run(3'd6, 6'h00, 16'h1234);
        chk("wral_done", got, 1);
        errs = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 16'h1234) errs++;
        chk("wral_all_words", errs, 0);
        chk("wral_keeps_rddata", rd_data, 16'hFFFF);

        // Async reset during WDATA bit 7 of a WRITE.
        issue(3'd1, 6'h05, 16'h0F0F, ok);
        n = 0;
        while (cnt != 17 && n < 1000) begin @(negedge clk); n++; end
        chk("reach_wdata_bit7", cnt, 17);
        #2 rst = 1'b1;
        #1;
        chk("arst_scs", scs, 0);
        chk("arst_sclk", sclk, 0);
        chk("arst_sdi", sdi, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_mem_kept", mem[5], 16'h1234);
        chk("arst_rddata", rd_data, 0);
        run(3'd0, 6'h05, 16'h0000);
        chk("arst_read_old", rd_data, 16'h1234);

        run(3'd7, 6'h00, 16'h0000);
        chk("nop_done", got, 1);
        chk("nop_fast", cyc <= 1, 1);
        chk("nop_no_cs", scs_seen, 0);

        stuck = 1'b1;
        run(3'd1, 6'h07, 16'h5555);
        chk("tmo_done", got, 1);
        chk("tmo_flag", to, 1);
        chk("tmo_poll_clocks", rises, 16);
        chk("tmo_keeps_rddata", rd_data, 16'h1234);
        stuck = 1'b0;
        run(3'd7, 6'h00, 16'h0000);
        chk("tmo_cleared", timeout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
